sram_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port 128b x 2048 SRAM among up to four requesters: SFU, corelet, and host load/store paths. It sits between the requesters and the SRAM macro. It drives the packed 141-bit `mem_in` control/data word and returns read data with a registered per-requester valid. It serializes all accesses because the SRAM admits exactly one read or write per cycle.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/rr_pick4.sv | 29 ++
 rtl/sram_arbiter.sv | 104 ++++++++++
 tb/tb_sram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM arbiter: geometry, packed mem_in field offsets
// and the deselected (idle) mem_in word.
package sram_arb_pkg;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 128;
    localparam int MEM_W    = DATA_W + ADDR_W + 2;

    localparam int CEN_BIT  = 140;
    localparam int WEN_BIT  = 139;
    localparam int ADDR_LSB = 128;

    // CEN and WEN are active-low, so idle means both high with zero address/data.
    localparam logic [MEM_W-1:0] MEM_IDLE = {2'b11, {(MEM_W-2){1'b0}}};

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating-priority picker: search starts one past
// last_grant and wraps mod 4; returns a one-hot grant and its index.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] grant,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        grant = '0;
        idx   = last_grant;
        cand  = last_grant;
        found = 1'b0;
        // k = 4 wraps back to last_grant itself, so it only wins when alone.
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter serializing four requesters onto one single-port SRAM.
// Define SRAM_ARB_LOCK_EN to enable bounded burst locking through req_lock.
module sram_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 128,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [DATA_W+ADDR_W+1:0]  mem_in,
    input  logic [DATA_W-1:0]         mem_out
);
    import sram_arb_pkg::*;

    localparam logic [5:0] LOCK_MAX_W = 6'(LOCK_MAX);

    logic [3:0] pick_grant;
    logic [1:0] pick_idx;
    logic [1:0] last_grant;
    logic [3:0] grant;
    logic [1:0] gidx;

    rr_pick4 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

`ifdef SRAM_ARB_LOCK_EN
    logic [4:0] lock_cnt;
    logic [5:0] cnt_inc;
    logic       hold;

    // lock_cnt counts beats already granted to last_grant under lock; zero means no lock.
    assign hold    = (lock_cnt != 5'd0) && req[last_grant] && req_lock[last_grant];
    assign cnt_inc = {1'b0, lock_cnt} + 6'd1;

    always_comb begin
        grant = pick_grant;
        gidx  = pick_idx;
        if (hold) begin
            grant = 4'b0001 << last_grant;
            gidx  = last_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else if (hold) begin
            lock_cnt <= (cnt_inc == LOCK_MAX_W) ? 5'd0 : cnt_inc[4:0];
        end else if (|grant && req_lock[gidx]) begin
            lock_cnt <= (LOCK_MAX_W <= 6'd1) ? 5'd0 : 5'd1;
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;

    assign grant       = pick_grant;
    assign gidx        = pick_idx;
    assign unused_lock = ^{req_lock, LOCK_MAX_W};
`endif

    // Handshake: req is held high until ack; ack marks the cycle the access
    // reaches the SRAM, and the requester may change its fields on that edge.
    always_comb begin
        ack    = '0;
        mem_in = MEM_IDLE;
        if (reset && |grant) begin
            ack                         = grant;
            mem_in[CEN_BIT]             = 1'b0;
            mem_in[WEN_BIT]             = ~req_we[gidx];
            mem_in[ADDR_LSB +: ADDR_W]  = req_addr[gidx*ADDR_W +: ADDR_W];
            mem_in[DATA_W-1:0]          = req_data[gidx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 2'd3;
            rd_valid   <= '0;
        end else begin
            rd_valid <= ack & ~req_we;
            if (|ack) begin
                last_grant <= gidx;
            end
        end
    end

    assign rd_data = mem_out;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle table plus reset, read-return,
// fairness and lock sequences against a behavioural SRAM.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic           clk;
    logic           reset;
    logic [3:0]     req;
    logic [3:0]     req_we;
    logic [43:0]    req_addr;
    logic [511:0]   req_data;
    logic [3:0]     req_lock;
    logic [3:0]     ack;
    logic [3:0]     rd_valid;
    logic [127:0]   rd_data;
    logic [140:0]   mem_in;
    logic [127:0]   mem_out;

    logic [127:0]   sram [2048];

    int checks = 0;
    int errors = 0;

    sram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_lock (req_lock),
        .ack      (ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_in[140]) begin
            if (!mem_in[139]) sram[mem_in[138:128]] <= mem_in[127:0];
            else              mem_out <= sram[mem_in[138:128]];
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] we;
        logic [3:0] exp_ack;
        logic [3:0] exp_rdv;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [10:0] addr_c(input int i);
        return 11'(i * 300 + 5);
    endfunction

    function automatic logic [127:0] data_c(input int i);
        logic [7:0] b;
        b = 8'(17 * (i + 1));
        return {16{b}};
    endfunction

    function automatic logic [140:0] exp_mem(input logic [3:0] a, input logic [3:0] we);
        logic [140:0] m;
        m = MEM_IDLE;
        for (int i = 0; i < 4; i++)
            if (a[i]) m = {1'b0, ~we[i], addr_c(i), data_c(i)};
        return m;
    endfunction

    function automatic logic [3:0] lock_exp(input int c);
`ifdef SRAM_ARB_LOCK_EN
        if (c == 0) return 4'b0001;
        if (c == 1) return 4'b0010;
        if (c < 18) return 4'b0100;
        return 4'b0001 << ((c - 18 + 3) % 4);
`else
        return 4'b0001 << (c % 4);
`endif
    endfunction

    task automatic chk(input string name, input logic [140:0] act, input logic [140:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
        req      = r;
        req_we   = w;
        req_lock = l;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int cnt [4];

        vecs[0]  = '{4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'hF, 4'h0, 4'h1, 4'h0};
        vecs[2]  = '{4'hF, 4'h0, 4'h2, 4'h1};
        vecs[3]  = '{4'hF, 4'hF, 4'h4, 4'h2};
        vecs[4]  = '{4'hF, 4'hF, 4'h8, 4'h0};
        vecs[5]  = '{4'hA, 4'h0, 4'h2, 4'h0};
        vecs[6]  = '{4'hA, 4'h0, 4'h8, 4'h2};
        vecs[7]  = '{4'h1, 4'h0, 4'h1, 4'h8};
        vecs[8]  = '{4'h1, 4'h0, 4'h1, 4'h1};
        vecs[9]  = '{4'h0, 4'h0, 4'h0, 4'h1};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'hC, 4'h4, 4'h4, 4'h0};
        vecs[12] = '{4'hC, 4'h0, 4'h8, 4'h0};
        vecs[13] = '{4'h6, 4'h0, 4'h2, 4'h8};

        for (int i = 0; i < 4; i++) begin
            req_addr[i*11 +: 11]   = addr_c(i);
            req_data[i*128 +: 128] = data_c(i);
        end

        // Reset held with all requests pending: nothing may reach the SRAM.
        reset = 1'b0;
        drive(4'hF, 4'h0, 4'h0);
        tick();
        tick();
        chk("reset_ack", 141'(ack), 141'(4'h0));
        chk("reset_cen_wen", 141'(mem_in[140:139]), 141'(2'b11));
        chk("reset_rd_valid", 141'(rd_valid), 141'(4'h0));

        reset = 1'b1;
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].req, vecs[v].we, 4'h0);
            #1;
            chk($sformatf("vec%0d_ack", v), 141'(ack), 141'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_mem_in", v), mem_in, exp_mem(vecs[v].exp_ack, vecs[v].we));
            chk($sformatf("vec%0d_rd_valid", v), 141'(rd_valid), 141'(vecs[v].exp_rdv));
            tick();
        end

        // Write then read-back of the top address by requester 1.
        drive(4'h0, 4'h0, 4'h0);
        #1;
        chk("wr_pre_rd_valid", 141'(rd_valid), 141'(4'h2));
        req_addr[11 +: 11]   = 11'h7FF;
        req_data[128 +: 128] = {16{8'hA5}};
        tick();
        drive(4'h2, 4'h2, 4'h0);
        #1;
        chk("wr_ack", 141'(ack), 141'(4'h2));
        chk("wr_mem_in", mem_in, {1'b0, 1'b0, 11'h7FF, {16{8'hA5}}});
        tick();
        drive(4'h2, 4'h0, 4'h0);
        #1;
        chk("rd_ack", 141'(ack), 141'(4'h2));
        chk("rd_mem_in", mem_in, {1'b0, 1'b1, 11'h7FF, {16{8'hA5}}});
        chk("wr_no_rd_valid", 141'(rd_valid), 141'(4'h0));
        tick();
        drive(4'h0, 4'h0, 4'h0);
        #1;
        chk("rd_ret_valid", 141'(rd_valid), 141'(4'h2));
        chk("rd_ret_data", 141'(rd_data), 141'({16{8'hA5}}));
        tick();
        chk("rd_ret_done", 141'(rd_valid), 141'(4'h0));

        // Reset asserted in the cycle a read return would appear.
        drive(4'h1, 4'h0, 4'h0);
        #1;
        chk("midrst_ack", 141'(ack), 141'(4'h1));
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_rd_valid", 141'(rd_valid), 141'(4'h0));
        chk("midrst_ack_low", 141'(ack), 141'(4'h0));
        chk("midrst_cen_wen", 141'(mem_in[140:139]), 141'(2'b11));
        tick();
        chk("midrst_rd_valid_hold", 141'(rd_valid), 141'(4'h0));
        reset = 1'b1;
        #1;
        chk("midrst_first_grant", 141'(ack), 141'(4'h1));

        // Fairness with every requester asking continuously.
        drive(4'h0, 4'h0, 4'h0);
        pulse_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive(4'hF, 4'h0, 4'h0);
        for (int c = 0; c < 400; c++) begin
            #1;
            chk($sformatf("fair_c%0d", c), 141'(ack), 141'(4'b0001 << (c % 4)));
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i]++;
            tick();
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_share%0d", i), 141'(cnt[i]), 141'(100));

        // Requester 2 asks for a lock while everyone requests.
        drive(4'h0, 4'h0, 4'h0);
        pulse_reset();
        drive(4'hF, 4'h0, 4'h4);
        for (int c = 0; c < 22; c++) begin
            #1;
            chk($sformatf("lock_c%0d", c), 141'(ack), 141'(lock_exp(c)));
            tick();
        end
        drive(4'h0, 4'h0, 4'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
